// File: rtl/tdp18k_half_model_if.sv
`default_nettype none
// ============================================================================
// tdp18k_half_model_if : port A / port B bus of one 18K BRAM half
// Revision 1.0
// ============================================================================
interface tdp18k_half_model_if;
  logic [13:0] ADDR_A_i;
  logic        REN_A_i;
  logic        WEN_A_i;
  logic [1:0]  BE_A_i;
  logic [17:0] WDATA_A_i;
  logic [17:0] RDATA_A_o;
  logic [13:0] ADDR_B_i;
  logic        REN_B_i;
  logic        WEN_B_i;
  logic [1:0]  BE_B_i;
  logic [17:0] WDATA_B_i;
  logic [17:0] RDATA_B_o;
  logic        FLUSH_i;
  logic        COLL_o;
  logic        ERR_o;

  modport master (
    output ADDR_A_i, REN_A_i, WEN_A_i, BE_A_i, WDATA_A_i,
    output ADDR_B_i, REN_B_i, WEN_B_i, BE_B_i, WDATA_B_i,
    output FLUSH_i,
    input  RDATA_A_o, RDATA_B_o, COLL_o, ERR_o
  );

  modport slave (
    input  ADDR_A_i, REN_A_i, WEN_A_i, BE_A_i, WDATA_A_i,
    input  ADDR_B_i, REN_B_i, WEN_B_i, BE_B_i, WDATA_B_i,
    input  FLUSH_i,
    output RDATA_A_o, RDATA_B_o, COLL_o, ERR_o
  );
endinterface
`default_nettype wire

// File: rtl/tdp18k_half_model.sv
`default_nettype none
// ============================================================================
// tdp18k_half_model : dual-port 1024x18 RAM half with TDP36K width modes
// Revision 1.0
// ============================================================================
module tdp18k_half_model #(
  parameter logic [2:0]     MODE_A = 3'b010,
  parameter logic [2:0]     MODE_B = 3'b010,
  parameter logic [18431:0] INIT   = '0
) (
  input  wire logic          CLK_i,
  input  wire logic          RESET_N_i,
  tdp18k_half_model_if.slave bus
);

  function automatic logic mode_legal(input logic [2:0] mode);
    case (mode)
      3'b010, 3'b001, 3'b100, 3'b110, 3'b101: mode_legal = 1'b1;
      default:                                mode_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [17:0] lane_mask(input logic [2:0] mode, input logic [3:0] lo,
                                            input logic [1:0] be);
    case (mode)
      3'b010:  lane_mask = {be[1], be[0], {8{be[1]}}, {8{be[0]}}};
      3'b001:  lane_mask = lo[3] ? 18'h2_FF00 : 18'h1_00FF;
      3'b100:  lane_mask = 18'h0_000F << {lo[3:2], 2'b00};
      3'b110:  lane_mask = 18'h0_0003 << {lo[3:1], 1'b0};
      3'b101:  lane_mask = 18'h0_0001 << lo;
      default: lane_mask = '0;
    endcase
  endfunction

  // Places the narrow write word at its lane position; bits outside the mask are don't-care.
  function automatic logic [17:0] lane_wdata(input logic [2:0] mode, input logic [3:0] lo,
                                             input logic [17:0] wd);
    case (mode)
      3'b010:  lane_wdata = wd;
      3'b001:  lane_wdata = lo[3] ? {wd[16], 1'b0, wd[7:0], 8'h00}
                                  : {1'b0, wd[16], 8'h00, wd[7:0]};
      3'b100:  lane_wdata = {14'b0, wd[3:0]} << {lo[3:2], 2'b00};
      3'b110:  lane_wdata = {16'b0, wd[1:0]} << {lo[3:1], 1'b0};
      3'b101:  lane_wdata = {17'b0, wd[0]} << lo;
      default: lane_wdata = '0;
    endcase
  endfunction

  function automatic logic [17:0] lane_rdata(input logic [2:0] mode, input logic [3:0] lo,
                                             input logic [17:0] row);
    case (mode)
      3'b010:  lane_rdata = row;
      3'b001:  lane_rdata = lo[3] ? {1'b0, row[17], 8'h00, row[15:8]}
                                  : {1'b0, row[16], 8'h00, row[7:0]};
      3'b100:  lane_rdata = {14'b0, row[{1'b0, lo[3:2], 2'b00} +: 4]};
      3'b110:  lane_rdata = {16'b0, row[{1'b0, lo[3:1], 1'b0} +: 2]};
      3'b101:  lane_rdata = {17'b0, row[{1'b0, lo}]};
      default: lane_rdata = '0;
    endcase
  endfunction

  function automatic logic [17:0] init_row(input logic [9:0] r);
    logic [14:0] base;
    base     = {1'b0, r, 4'b0000} + {4'b0000, r, 1'b0};
    init_row = INIT[base +: 18];
  endfunction

  localparam logic c_LEGAL_A = mode_legal(MODE_A);
  localparam logic c_LEGAL_B = mode_legal(MODE_B);

  // The array holds each row XOR its INIT value, so the all-zero power-up state reads as INIT.
  logic [17:0] mem_q [1024];

  logic [9:0]  w_row_a, w_row_b;
  logic [17:0] w_old_a, w_old_b;
  logic [17:0] w_mask_a, w_mask_b, w_mask_b_eff;
  logic [17:0] w_wd_a, w_wd_b;
  logic        w_same_row;
  logic [17:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic        coll_q, coll_d, err_q, err_d;

  assign w_row_a    = bus.ADDR_A_i[13:4];
  assign w_row_b    = bus.ADDR_B_i[13:4];
  assign w_old_a    = mem_q[w_row_a] ^ init_row(w_row_a);
  assign w_old_b    = mem_q[w_row_b] ^ init_row(w_row_b);
  assign w_mask_a   = (c_LEGAL_A && bus.WEN_A_i) ? lane_mask(MODE_A, bus.ADDR_A_i[3:0], bus.BE_A_i) : '0;
  assign w_mask_b   = (c_LEGAL_B && bus.WEN_B_i) ? lane_mask(MODE_B, bus.ADDR_B_i[3:0], bus.BE_B_i) : '0;
  assign w_wd_a     = lane_wdata(MODE_A, bus.ADDR_A_i[3:0], bus.WDATA_A_i);
  assign w_wd_b     = lane_wdata(MODE_B, bus.ADDR_B_i[3:0], bus.WDATA_B_i);
  assign w_same_row = (w_row_a == w_row_b);
  // Port A owns any bit both ports write in the same row.
  assign w_mask_b_eff = w_same_row ? (w_mask_b & ~w_mask_a) : w_mask_b;

  always_ff @(posedge CLK_i) begin
    if (w_same_row) begin
      if (|(w_mask_a | w_mask_b))
        mem_q[w_row_a] <= ((w_old_a & ~(w_mask_a | w_mask_b_eff)) | (w_wd_a & w_mask_a)
                           | (w_wd_b & w_mask_b_eff)) ^ init_row(w_row_a);
    end else begin
      if (|w_mask_a)
        mem_q[w_row_a] <= ((w_old_a & ~w_mask_a) | (w_wd_a & w_mask_a)) ^ init_row(w_row_a);
      if (|w_mask_b)
        mem_q[w_row_b] <= ((w_old_b & ~w_mask_b) | (w_wd_b & w_mask_b)) ^ init_row(w_row_b);
    end
  end

  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (bus.REN_A_i) rdata_a_d = lane_rdata(MODE_A, bus.ADDR_A_i[3:0], w_old_a);
    if (bus.REN_B_i) rdata_b_d = lane_rdata(MODE_B, bus.ADDR_B_i[3:0], w_old_b);
    if (!c_LEGAL_A)  rdata_a_d = '0;
    if (!c_LEGAL_B)  rdata_b_d = '0;
    if (bus.FLUSH_i) begin
      rdata_a_d = '0;
      rdata_b_d = '0;
    end
    coll_d = w_same_row && (|(w_mask_a & w_mask_b));
    err_d  = err_q | ~(c_LEGAL_A & c_LEGAL_B);
  end

  always_ff @(posedge CLK_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      coll_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      coll_q    <= coll_d;
      err_q     <= err_d;
    end
  end

  assign bus.RDATA_A_o = rdata_a_q;
  assign bus.RDATA_B_o = rdata_b_q;
  assign bus.COLL_o    = coll_q;
  assign bus.ERR_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdp18k_half_model.sv
`default_nettype none
// ============================================================================
// tb_tdp18k_half_model : four mode combinations driven in parallel, scoreboarded
// Revision 1.0
// ============================================================================
module tb_tdp18k_half_model;

  localparam int          N   = 4;
  localparam logic [17:0] PAT = 18'h2_5A3C;
  localparam logic [2:0]  MA [N] = '{3'b010, 3'b001, 3'b100, 3'b101};
  localparam logic [2:0]  MB [N] = '{3'b010, 3'b010, 3'b110, 3'b011};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        rst_next = 1'b0;
  logic [13:0] addr_a = '0, addr_b = '0;
  logic        ren_a = 1'b0, wen_a = 1'b0, ren_b = 1'b0, wen_b = 1'b0, flush = 1'b0;
  logic [1:0]  be_a = '0, be_b = '0;
  logic [17:0] wd_a = '0, wd_b = '0;

  logic [17:0] rda [N];
  logic [17:0] rdb [N];
  logic        coll [N];
  logic        err [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    tdp18k_half_model_if bus ();
    assign bus.ADDR_A_i  = addr_a;
    assign bus.REN_A_i   = ren_a;
    assign bus.WEN_A_i   = wen_a;
    assign bus.BE_A_i    = be_a;
    assign bus.WDATA_A_i = wd_a;
    assign bus.ADDR_B_i  = addr_b;
    assign bus.REN_B_i   = ren_b;
    assign bus.WEN_B_i   = wen_b;
    assign bus.BE_B_i    = be_b;
    assign bus.WDATA_B_i = wd_b;
    assign bus.FLUSH_i   = flush;
    assign rda[g]  = bus.RDATA_A_o;
    assign rdb[g]  = bus.RDATA_B_o;
    assign coll[g] = bus.COLL_o;
    assign err[g]  = bus.ERR_o;
    tdp18k_half_model #(
      .MODE_A (MA[g]),
      .MODE_B (MB[g]),
      .INIT   (g == 0 ? 18432'b0 : {1024{PAT}})
    ) u_dut (
      .CLK_i     (clk),
      .RESET_N_i (rst_n),
      .bus       (bus)
    );
  end

  // ---------------- reference model: memory as individually addressed bits
  logic [17:0] m_mem [N][1024];
  logic [17:0] m_rd  [N][2];
  logic        m_coll [N];
  logic        m_err  [N];

  typedef struct {
    int          cyc;
    int          inst;
    int          kind;
    logic [17:0] val;
  } exp_t;
  exp_t exp_q[$];

  int edge_n = 0;
  int vectors = 0;
  int miscompares = 0;
  string kname [4] = '{"RDATA_A", "RDATA_B", "COLL", "ERR"};

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int width_of(input logic [2:0] m);
    case (m)
      3'b010:  return 18;
      3'b001:  return 9;
      3'b100:  return 4;
      3'b110:  return 2;
      3'b101:  return 1;
      default: return 0;
    endcase
  endfunction

  // Row bit holding lane bit k.
  function automatic int bitpos(input logic [2:0] m, input logic [3:0] lo, input int k);
    case (m)
      3'b010:  return k;
      3'b001:  return (k < 8) ? 8 * int'(lo[3]) + k : 16 + int'(lo[3]);
      3'b100:  return 4 * int'(lo[3:2]) + k;
      3'b110:  return 2 * int'(lo[3:1]) + k;
      default: return int'(lo);
    endcase
  endfunction

  // xDATA bit carrying lane bit k.
  function automatic int dbit(input logic [2:0] m, input int k);
    return (m == 3'b001 && k == 8) ? 16 : k;
  endfunction

  function automatic logic enabled(input logic [2:0] m, input logic [1:0] be, input int k);
    int b;
    if (m != 3'b010) return 1'b1;
    b = (k >= 16) ? k - 16 : k / 8;
    return be[b];
  endfunction

  function automatic void push(input int cyc, input int inst, input int kind, input logic [17:0] v);
    exp_t e;
    e.cyc = cyc; e.inst = inst; e.kind = kind; e.val = v;
    exp_q.push_back(e);
  endfunction

  task automatic model_edge();
    logic [13:0] ad [2];
    logic        re [2];
    logic        we [2];
    logic [1:0]  be [2];
    logic [17:0] wd [2];
    logic [2:0]  md [2];
    logic [17:0] tm [2];
    logic [17:0] td [2];
    logic [17:0] rv [2];
    int          rw [2];
    int          w, pos;
    logic        c;
    ad[0] = addr_a; re[0] = ren_a; we[0] = wen_a; be[0] = be_a; wd[0] = wd_a;
    ad[1] = addr_b; re[1] = ren_b; we[1] = wen_b; be[1] = be_b; wd[1] = wd_b;
    for (int i = 0; i < N; i++) begin
      md[0] = MA[i];
      md[1] = MB[i];
      for (int p = 0; p < 2; p++) begin
        w     = width_of(md[p]);
        rw[p] = int'(ad[p][13:4]);
        rv[p] = '0; tm[p] = '0; td[p] = '0;
        for (int k = 0; k < w; k++) begin
          pos = bitpos(md[p], ad[p][3:0], k);
          rv[p][dbit(md[p], k)] = m_mem[i][rw[p]][pos];
          if (we[p] && enabled(md[p], be[p], k)) begin
            tm[p][pos] = 1'b1;
            td[p][pos] = wd[p][dbit(md[p], k)];
          end
        end
      end
      c = (rw[0] == rw[1]) && ((tm[0] & tm[1]) != 18'h0);
      // B first, then A, so A owns overlapping bits.
      for (int p = 1; p >= 0; p--)
        m_mem[i][rw[p]] = (m_mem[i][rw[p]] & ~tm[p]) | (td[p] & tm[p]);
      for (int p = 0; p < 2; p++) begin
        if (!rst_n || width_of(md[p]) == 0 || flush) m_rd[i][p] = '0;
        else if (re[p])                                m_rd[i][p] = rv[p];
      end
      m_coll[i] = rst_n && c;
      if (!rst_n) m_err[i] = 1'b0;
      else if (width_of(MA[i]) == 0 || width_of(MB[i]) == 0) m_err[i] = 1'b1;
      push(edge_n + 1, i, 0, m_rd[i][0]);
      push(edge_n + 1, i, 1, m_rd[i][1]);
      push(edge_n + 1, i, 2, {17'b0, m_coll[i]});
      push(edge_n + 1, i, 3, {17'b0, m_err[i]});
    end
  endtask

  task automatic drive(input logic [13:0] aa, input logic ra, input logic wa, input logic [1:0] ba,
                       input logic [17:0] da, input logic [13:0] ab, input logic rb, input logic wb,
                       input logic [1:0] bb, input logic [17:0] db, input logic fl);
    @(negedge clk);
    #1;
    rst_n  = rst_next;
    addr_a = aa; ren_a = ra; wen_a = wa; be_a = ba; wd_a = da;
    addr_b = ab; ren_b = rb; wen_b = wb; be_b = bb; wd_b = db;
    flush  = fl;
    model_edge();
  endtask

  task automatic idle();
    drive(14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
  endtask

  task automatic expect_const(input int inst, input int kind, input logic [17:0] v, input int dly);
    push(edge_n + dly, inst, kind, v);
  endtask

  // Asserts reset in the high phase right after the edge of the last drive.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    rst_next = 1'b0;
    foreach (exp_q[j]) if (exp_q[j].cyc == edge_n) exp_q[j].val = '0;
    for (int i = 0; i < N; i++) begin
      m_rd[i][0] = '0; m_rd[i][1] = '0; m_coll[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  // ---------------- monitor
  initial begin
    exp_t        keep[$];
    logic [17:0] act;
    forever begin
      @(negedge clk);
      keep.delete();
      foreach (exp_q[j]) begin
        if (exp_q[j].cyc <= edge_n) begin
          case (exp_q[j].kind)
            0:       act = rda[exp_q[j].inst];
            1:       act = rdb[exp_q[j].inst];
            2:       act = {17'b0, coll[exp_q[j].inst]};
            default: act = {17'b0, err[exp_q[j].inst]};
          endcase
          vectors++;
          if (act !== exp_q[j].val) begin
            miscompares++;
            $display("FAIL %s inst%0d edge%0d: got %h expected %h",
                     kname[exp_q[j].kind], exp_q[j].inst, exp_q[j].cyc, act, exp_q[j].val);
          end
        end else begin
          keep.push_back(exp_q[j]);
        end
      end
      exp_q = keep;
    end
  end

  // ---------------- stimulus
  initial begin
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < 1024; r++) m_mem[i][r] = (i == 0) ? 18'h0 : PAT;
      m_rd[i][0] = '0; m_rd[i][1] = '0; m_coll[i] = 1'b0; m_err[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    expect_const(0, 0, 18'h0, 1);
    expect_const(3, 3, 18'h0, 1);
    idle();
    idle();
    // Write presented on the reset-release edge.
    rst_next = 1'b1;
    drive(14'h0090, 1'b0, 1'b1, 2'b11, 18'h1_5555, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(3, 3, 18'h1, 1);
    expect_const(0, 3, 18'h0, 1);

    // x18 write then read
    drive(14'h0010, 1'b0, 1'b1, 2'b11, 18'h3_A5C3, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    drive(14'h0010, 1'b1, 1'b0, 2'b00, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(0, 0, 18'h3_A5C3, 1);

    // x9 write on A, x18 read of the whole row on B
    drive(14'h0028, 1'b0, 1'b1, 2'b11, 18'h1_007E, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    drive(14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 14'h0020, 1'b1, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(1, 1, 18'h2_7E3C, 1);

    // Byte-enable gating
    drive(14'h0030, 1'b0, 1'b1, 2'b11, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    drive(14'h0030, 1'b0, 1'b1, 2'b01, 18'h3_FFFF, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    drive(14'h0030, 1'b1, 1'b0, 2'b00, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(0, 0, 18'h1_00FF, 1);

    // Cross-port write collision
    drive(14'h0050, 1'b0, 1'b1, 2'b11, 18'h0_0001, 14'h0050, 1'b0, 1'b1, 2'b11, 18'h3_FFFE, 1'b0);
    expect_const(0, 2, 18'h1, 1);
    idle();
    expect_const(0, 2, 18'h0, 1);
    drive(14'h0050, 1'b1, 1'b0, 2'b00, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(0, 0, 18'h0_0001, 1);

    // Same-port read-first
    drive(14'h0070, 1'b0, 1'b1, 2'b11, 18'h1_2345, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    drive(14'h0070, 1'b1, 1'b1, 2'b11, 18'h0_ABCD, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(0, 0, 18'h1_2345, 1);
    drive(14'h0070, 1'b1, 1'b0, 2'b00, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(0, 0, 18'h0_ABCD, 1);

    // Flush overrides reads on both ports
    drive(14'h0070, 1'b1, 1'b0, 2'b00, 18'h0, 14'h0070, 1'b1, 1'b0, 2'b00, 18'h0, 1'b1);
    expect_const(0, 0, 18'h0, 1);
    expect_const(0, 1, 18'h0, 1);

    // Asynchronous reset right after a read edge, then contents survive
    drive(14'h0070, 1'b1, 1'b0, 2'b00, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    async_reset();
    expect_const(0, 0, 18'h0, 0);
    idle();
    rst_next = 1'b1;
    drive(14'h0070, 1'b1, 1'b0, 2'b00, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(0, 0, 18'h0_ABCD, 1);
    drive(14'h0090, 1'b1, 1'b0, 2'b00, 18'h0, 14'h0, 1'b0, 1'b0, 2'b00, 18'h0, 1'b0);
    expect_const(0, 0, 18'h1_5555, 1);

    // Randomised traffic confined to a few rows so collisions are frequent
    for (int n = 0; n < 400; n++) begin
      drive({7'($urandom_range(0, 7)) & 7'h07, 7'($urandom)},
            1'($urandom), 1'($urandom), 2'($urandom), 18'($urandom),
            {7'($urandom_range(0, 7)) & 7'h07, 7'($urandom)},
            1'($urandom), 1'($urandom), 2'($urandom), 18'($urandom),
            ($urandom_range(0, 15) == 0));
    end
    idle();

    repeat (3) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
